shifter_pipelined: RTL
======================

// Module: shifter_pipelined
// PURPOSE
//   Parametrised, pipelined barrel shifter for the datapath/ALU. Performs a
//   logical-left, logical-right, arithmetic-right, rotate-left or rotate-right
//   on an N-bit operand, using one log2 stage per shift-amount bit. A
//   valid/ready handshake on both sides gives full throughput and backpressure.
// PARAMETERS
//   N       32  operand width in bits; must be a power of two, >= 4
//   REG_EN  1   1: register every stage (latency L = $clog2(N)); 0: comb (L = 0)
// PORTS
//   clk        input   1           clock; all state updates on posedge
//   rst        input   1           synchronous, active-high reset
//   in_valid   input   1           in_data/in_shamt/in_op are valid this cycle
//   in_ready   output  1           block accepts the input this cycle
//   in_data    input   N           operand to shift
//   in_shamt   input   $clog2(N)   shift amount, 0..N-1, unsigned
//   in_op      input   3           shift_op_t (see package)
//   out_valid  output  1           out_data holds a finished result
//   out_ready  input   1           consumer takes out_data this cycle
//   out_data   output  N           shifted result
// BEHAVIOUR
//   - Reset: all stage valid bits 0, all stage data 0, so out_valid=0 and
//     out_data=0; in_ready=1 in the first cycle after reset is released.
//   - rst mid-operation drops every in-flight result; nothing is emitted.
//   - Ops:
//     SLL=0: zero-fill from the LSB.
//     SRL=1: zero-fill from the MSB.
//     SRA=2: fill from the MSB with in_data[N-1].
//     ROL=3, ROR=4: bits shifted out re-enter at the opposite end.
//     Codes 5-7: out_data = in_data (pass-through).
//   - shamt=0 returns in_data unchanged for every op. N-1 is the maximum
//     shift; there is no out-of-range input.
//   - Stage k (k=0..L-1) conditionally shifts by 2**k when shamt[k]=1. Each
//     stage register carries data, remaining shamt, op and a valid bit.
//   - Handshake:
//     advance = !out_valid | out_ready; in_ready = advance.
//     Input transfer when in_valid & in_ready. Output transfer when
//     out_valid & out_ready.
//     When advance=1, every stage loads from the stage before it; stage 0
//     loads the input and sets valid = in_valid.
//     When advance=0, the whole pipeline holds and out_data stays stable.
//   - Latency: a transfer in cycle t gives out_valid in cycle t+L, provided
//     the pipeline was not stalled.
//   - Throughput: one result per cycle while out_ready=1.
//   - Simultaneous output transfer and input transfer in the same cycle is
//     legal and loses nothing. Bubbles (in_valid=0) propagate as valid=0
//     slots and are not compacted.
//   - in_ready is combinational from out_ready (no skid buffer). The upstream
//     side must not wait for in_ready before asserting in_valid.
//   - REG_EN=0: out_valid=in_valid, in_ready=out_ready, and out_data is purely
//     combinational.
// STRUCTURE
//   - shifter_pkg: shift_op_t enum logic [2:0] {SHIFT_SLL, SHIFT_SRL,
//     SHIFT_SRA, SHIFT_ROL, SHIFT_ROR}.
//   - Sub-module shifter_stage #(N, DIST): one conditional shift by DIST for
//     all five ops. Comb core, optional output register, generated
//     $clog2(N) times with DIST = 1,2,4,...
//   - Top level: stage chain, valid bits and the advance logic only.
// TESTING  (N=32, REG_EN=1, L=5)
//   1. Basic ops, out_ready=1, in_data=32'h8000_00F1, shamt=4:
//      SLL -> 32'h0000_0F10; SRL -> 32'h0800_000F; SRA -> 32'hF800_000F;
//      ROL -> 32'h0000_0F18; ROR -> 32'h1800_000F. Each result appears
//      exactly 5 cycles after its input transfer.
//   2. Edges, in_data=32'hFFFF_FFFF:
//      shamt=0 SRA -> 32'hFFFF_FFFF; shamt=31 SLL -> 32'h8000_0000;
//      shamt=31 SRL -> 32'h0000_0001; op=7 -> pass-through.
//   3. Streaming: 64 back-to-back random inputs with out_ready=1 give 64
//      results in order, one per cycle, all matching the reference model.
//   4. Backpressure: fill the pipeline, drop out_ready for 3 cycles ->
//      in_ready=0, out_data/out_valid held. Release -> no loss or duplicate.
//   5. Bubbles: in_valid pattern 1,0,1,1,0 -> out_valid shows the same
//      pattern 5 cycles later.
//   6. Reset: assert rst with 3 items in flight -> out_valid=0, out_data=0
//      next cycle. No stale result appears after rst is released.

Source files
------------

// File: rtl/shifter_pkg.sv
// ============================================================================
// shifter_pkg : shared shift-operation encoding for the pipelined shifter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package shifter_pkg;

   localparam int OP_W = 3;

   // Codes 5-7 are not named; they select pass-through.
   typedef enum logic [OP_W-1:0] {
      SHIFT_SLL = 3'd0,
      SHIFT_SRL = 3'd1,
      SHIFT_SRA = 3'd2,
      SHIFT_ROL = 3'd3,
      SHIFT_ROR = 3'd4
   } shift_op_t;

endpackage

`default_nettype wire

// File: rtl/shifter_stage.sv
// ============================================================================
// shifter_stage : one conditional shift by DIST for all five ops, optional
//                 output register that carries data, shamt, op and valid
// Revision      : 1.0
// ============================================================================
`default_nettype none

module shifter_stage
   import shifter_pkg::*;
#(
   parameter int N      = 32,
   parameter int DIST   = 1,
   parameter bit REG_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 advance,
   input  logic                 in_valid,
   input  logic [N-1:0]         in_data,
   input  logic [$clog2(N)-1:0] in_shamt,
   input  logic [OP_W-1:0]      in_op,
   output logic                 out_valid,
   output logic [N-1:0]         out_data,
   output logic [$clog2(N)-1:0] out_shamt,
   output logic [OP_W-1:0]      out_op
);

   localparam int SH_W    = $clog2(N);
   localparam int SEL_BIT = $clog2(DIST);

   logic [N-1:0] w_shifted;

   always_comb begin
      w_shifted = in_data;
      if (in_shamt[SEL_BIT]) begin
         case (in_op)
            SHIFT_SLL: w_shifted = in_data << DIST;
            SHIFT_SRL: w_shifted = in_data >> DIST;
            SHIFT_SRA: w_shifted = {{DIST{in_data[N-1]}}, in_data[N-1:DIST]};
            SHIFT_ROL: w_shifted = {in_data[N-1-DIST:0], in_data[N-1:N-DIST]};
            SHIFT_ROR: w_shifted = {in_data[DIST-1:0], in_data[N-1:DIST]};
            default:   w_shifted = in_data;
         endcase
      end
   end

   generate
      if (REG_EN) begin : g_reg
         always_ff @(posedge clk) begin
            if (rst) begin
               out_valid <= 1'b0;
               out_data  <= '0;
               out_shamt <= '0;
               out_op    <= '0;
            end else if (advance) begin
               out_valid <= in_valid;
               out_data  <= w_shifted;
               out_shamt <= in_shamt;
               out_op    <= in_op;
            end
         end
      end else begin : g_comb
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, rst, advance};
         assign out_valid   = in_valid;
         assign out_data    = w_shifted;
         assign out_shamt   = in_shamt;
         assign out_op      = in_op;
      end
   endgenerate

   logic [SH_W-1:0] unused_shamt_w;
   assign unused_shamt_w = in_shamt;

endmodule

`default_nettype wire

// File: rtl/shifter_pipelined.sv
// ============================================================================
// shifter_pipelined : log2(N)-stage barrel shifter with valid/ready handshake;
//                     the whole chain advances or holds as one unit
// Revision          : 1.0
// ============================================================================
`default_nettype none

module shifter_pipelined
   import shifter_pkg::*;
#(
   parameter int N      = 32,
   parameter bit REG_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_data,
   input  logic [$clog2(N)-1:0] in_shamt,
   input  logic [OP_W-1:0]      in_op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         out_data
);

   localparam int L    = $clog2(N);
   localparam int SH_W = $clog2(N);

   logic              valid_q [L+1];
   logic [N-1:0]      data_q  [L+1];
   logic [SH_W-1:0]   shamt_q [L+1];
   logic [OP_W-1:0]   op_q    [L+1];
   logic              advance;

   assign valid_q[0] = in_valid;
   assign data_q[0]  = in_data;
   assign shamt_q[0] = in_shamt;
   assign op_q[0]    = in_op;

   generate
      for (genvar k = 0; k < L; k++) begin : g_stage
         shifter_stage #(
            .N      (N),
            .DIST   (1 << k),
            .REG_EN (REG_EN)
         ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .advance   (advance),
            .in_valid  (valid_q[k]),
            .in_data   (data_q[k]),
            .in_shamt  (shamt_q[k]),
            .in_op     (op_q[k]),
            .out_valid (valid_q[k+1]),
            .out_data  (data_q[k+1]),
            .out_shamt (shamt_q[k+1]),
            .out_op    (op_q[k+1])
         );
      end
   endgenerate

   assign out_valid = valid_q[L];
   assign out_data  = data_q[L];

   // No skid buffer: a free or draining output slot lets every stage move.
   assign advance  = !out_valid || out_ready;
   assign in_ready = REG_EN ? advance : out_ready;

   logic unused_tail;
   assign unused_tail = ^{shamt_q[L], op_q[L]};

endmodule

`default_nettype wire
